// File: rtl/inorder_commit_unit_pkg.sv
// ----------------------------------------------------------------------------
// inorder_commit_unit_pkg
// Shared types and sizing for the in-order commit unit.
//   NrVFU        number of VFU completion channels
//   InsnIDNum    in-flight instruction ID slots (power of 2, >= 2)
//   CommitWidth  maximum retirements per cycle (1..InsnIDNum)
//   insn_id_t    instruction ID, wraps naturally modulo InsnIDNum
//   insn_cnt_t   occupancy count, 0..InsnIDNum inclusive
//   commit_state_e  per-ID lifecycle state
// ----------------------------------------------------------------------------
package inorder_commit_unit_pkg;

    localparam int NrVFU       = 4;
    localparam int InsnIDNum   = 8;
    localparam int CommitWidth = 2;
    localparam int InsnIDW     = $clog2(InsnIDNum);

    typedef logic [InsnIDW-1:0] insn_id_t;
    typedef logic [InsnIDW:0]   insn_cnt_t;

    typedef enum logic [1:0] {
        FREE,
        PENDING,
        DONE,
        ILLEGAL
    } commit_state_e;

    // An entry may leave the window once it has finished, either normally or
    // because it was flagged illegal at issue.
    function automatic logic is_retirable(commit_state_e s);
        return (s == DONE) || (s == ILLEGAL);
    endfunction

endpackage

// File: rtl/inorder_commit_unit_commit_window_scan.sv
// ----------------------------------------------------------------------------
// inorder_commit_unit_commit_window_scan
// Purely combinational scan of the oldest CommitWidth entries (already
// rotated so that index 0 is the head).
//   win_state  in   entry states, head first
//   count      in   number of occupied entries
//   valid      out  contiguous retire mask starting at lane 0
//   illegal    out  lane holds an illegal instruction
// ----------------------------------------------------------------------------
module inorder_commit_unit_commit_window_scan
    import inorder_commit_unit_pkg::*;
(
    input  commit_state_e           win_state [CommitWidth],
    input  insn_cnt_t               count,
    output logic [CommitWidth-1:0]  valid,
    output logic [CommitWidth-1:0]  illegal
);

    always_comb begin
        logic run;
        run     = 1'b1;
        valid   = '0;
        illegal = '0;
        for (int j = 0; j < CommitWidth; j++) begin
            // A lane is valid only if it and every older lane can retire;
            // the first blocker stops the run so lanes stay contiguous.
            run        = run && is_retirable(win_state[j]) && (insn_cnt_t'(j) < count);
            valid[j]   = run;
            illegal[j] = (win_state[j] == ILLEGAL);
        end
    end

endmodule

// File: rtl/inorder_commit_unit.sv
// ----------------------------------------------------------------------------
// inorder_commit_unit
// In-order instruction ID allocator and multi-lane retire stage. IDs are
// handed out at the tail, any number of VFUs may complete in one cycle, and
// up to CommitWidth of the oldest finished instructions retire per cycle.
// Optional feature macro: RVV_COMMIT_PERF_EN (retire / stall counters).
//   clk_i, rst_ni                clock, asynchronous active-low reset
//   issue_valid_i/illegal_insn_i decoder issue and its illegal qualifier
//   alloc_id_o, full_o           next ID to allocate, no free ID
//   vfu_done_i/_id_i/_gnt_o      per-VFU completions, always accepted
//   insn_can_commit_i/_id_i      set a bit of the can-commit bitmap
//   insn_can_commit_o            registered can-commit bitmap
//   commit_valid_o/_id_o/_illegal_o  retire lanes, lane j = head+j
//   commit_ready_i               consumer takes all valid lanes
//   perf_retired_o/perf_stall_o  performance counters (zero when disabled)
// ----------------------------------------------------------------------------
module inorder_commit_unit
    import inorder_commit_unit_pkg::*;
(
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            issue_valid_i,
    input  logic                            illegal_insn_i,
    output logic [InsnIDW-1:0]              alloc_id_o,
    output logic                            full_o,
    input  logic [NrVFU-1:0]                vfu_done_i,
    input  logic [NrVFU*InsnIDW-1:0]        vfu_done_id_i,
    output logic [NrVFU-1:0]                vfu_done_gnt_o,
    input  logic                            insn_can_commit_i,
    input  logic [InsnIDW-1:0]              insn_can_commit_id_i,
    output logic [InsnIDNum-1:0]            insn_can_commit_o,
    output logic [CommitWidth-1:0]          commit_valid_o,
    output logic [CommitWidth*InsnIDW-1:0]  commit_id_o,
    output logic [CommitWidth-1:0]          commit_illegal_o,
    input  logic                            commit_ready_i,
    output logic [31:0]                     perf_retired_o,
    output logic [31:0]                     perf_stall_o
);

    commit_state_e          state_q [InsnIDNum];
    insn_id_t               head_q;
    insn_id_t               tail_q;
    insn_cnt_t              count_q;
    logic [InsnIDNum-1:0]   bitmap_q;

    commit_state_e          win_state [CommitWidth];
    logic [CommitWidth-1:0] lane_valid;
    logic [CommitWidth-1:0] retire;
    insn_cnt_t              n_retire;
    logic                   full;
    logic                   issue;

    // Full is taken from the registered count, so a slot freed this cycle
    // only becomes allocatable next cycle.
    assign full           = (count_q == insn_cnt_t'(InsnIDNum));
    assign issue          = issue_valid_i && !full;
    assign full_o         = full;
    assign alloc_id_o     = tail_q;
    assign vfu_done_gnt_o = vfu_done_i;
    assign insn_can_commit_o = bitmap_q;

    always_comb begin
        for (int j = 0; j < CommitWidth; j++) begin
            win_state[j] = state_q[head_q + insn_id_t'(j)];
        end
    end

    inorder_commit_unit_commit_window_scan u_scan (
        .win_state (win_state),
        .count     (count_q),
        .valid     (lane_valid),
        .illegal   (commit_illegal_o)
    );

    assign commit_valid_o = lane_valid;
    assign retire         = lane_valid & {CommitWidth{commit_ready_i}};

    for (genvar j = 0; j < CommitWidth; j++) begin : g_commit_id
        assign commit_id_o[j*InsnIDW +: InsnIDW] = head_q + insn_id_t'(j);
    end

    always_comb begin
        n_retire = '0;
        for (int j = 0; j < CommitWidth; j++) begin
            n_retire = n_retire + insn_cnt_t'(retire[j]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < InsnIDNum; i++) begin
                state_q[i] <= FREE;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            bitmap_q <= '0;
        end else begin
            for (int k = 0; k < NrVFU; k++) begin
                if (vfu_done_i[k]) begin
                    state_q[vfu_done_id_i[k*InsnIDW +: InsnIDW]] <= DONE;
                end
            end
            // Bitmap set first so that a same-cycle retire or issue clear wins.
            if (insn_can_commit_i) begin
                bitmap_q[insn_can_commit_id_i] <= 1'b1;
            end
            for (int j = 0; j < CommitWidth; j++) begin
                if (retire[j]) begin
                    state_q[head_q + insn_id_t'(j)]  <= FREE;
                    bitmap_q[head_q + insn_id_t'(j)] <= 1'b0;
                end
            end
            // The tail slot is FREE and outside the retire window, so no
            // other update in this block can target it legitimately.
            if (issue) begin
                state_q[tail_q]  <= illegal_insn_i ? ILLEGAL : PENDING;
                bitmap_q[tail_q] <= 1'b0;
            end
            head_q  <= head_q + insn_id_t'(n_retire);
            tail_q  <= tail_q + insn_id_t'(issue);
            count_q <= count_q + insn_cnt_t'(issue) - n_retire;
        end
    end

`ifdef RVV_COMMIT_PERF_EN
    logic [31:0] perf_retired_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_retired_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_retired_q <= perf_retired_q + 32'(n_retire);
            if ((count_q != '0) && !lane_valid[0]) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_retired_o = perf_retired_q;
    assign perf_stall_o   = perf_stall_q;
`else
    assign perf_retired_o = '0;
    assign perf_stall_o   = '0;
`endif

    // Protocol checks on upstream behaviour.
    a_issue_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(issue_valid_i && full))
        else $error("issue asserted while full");

    for (genvar k = 0; k < NrVFU; k++) begin : g_done_chk
        a_done_pending : assert property (@(posedge clk_i) disable iff (!rst_ni)
            vfu_done_i[k] |-> (state_q[vfu_done_id_i[k*InsnIDW +: InsnIDW]] == PENDING))
            else $error("completion to non-pending ID on VFU %0d", k);
    end

endmodule

// File: tb/tb_inorder_commit_unit.sv
// ----------------------------------------------------------------------------
// tb_inorder_commit_unit
// Directed scenarios followed by randomized traffic, checked every cycle
// against a program-order queue model of in-flight instructions.
// ----------------------------------------------------------------------------
module tb_inorder_commit_unit;

    logic        clk;
    logic        rst_ni;
    logic        issue_valid;
    logic        illegal_insn;
    logic [2:0]  alloc_id;
    logic        full;
    logic [3:0]  vfu_done;
    logic [11:0] vfu_done_id;
    logic [3:0]  vfu_gnt;
    logic        cc_valid;
    logic [2:0]  cc_id;
    logic [7:0]  bitmap;
    logic [1:0]  cvalid;
    logic [5:0]  cid;
    logic [1:0]  cill;
    logic        cready;
    logic [31:0] perf_ret;
    logic [31:0] perf_stall;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0] id;
        bit         done;
        bit         ill;
    } ent_t;

    ent_t        q[$];
    int          alloc;
    logic [7:0]  bm;
    int unsigned m_ret;
    int unsigned m_stall;

    inorder_commit_unit dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .issue_valid_i        (issue_valid),
        .illegal_insn_i       (illegal_insn),
        .alloc_id_o           (alloc_id),
        .full_o               (full),
        .vfu_done_i           (vfu_done),
        .vfu_done_id_i        (vfu_done_id),
        .vfu_done_gnt_o       (vfu_gnt),
        .insn_can_commit_i    (cc_valid),
        .insn_can_commit_id_i (cc_id),
        .insn_can_commit_o    (bitmap),
        .commit_valid_o       (cvalid),
        .commit_id_o          (cid),
        .commit_illegal_o     (cill),
        .commit_ready_i       (cready),
        .perf_retired_o       (perf_ret),
        .perf_stall_o         (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Number of leading finished entries, capped at the retire width.
    function automatic int exp_n();
        int n = 0;
        while (n < 2 && n < q.size() && (q[n].done || q[n].ill)) n++;
        return n;
    endfunction

    task automatic check_outputs();
        int en;
        int head;
        en   = exp_n();
        head = (alloc - q.size()) % 8;
        check("valid", 32'(cvalid), 32'((1 << en) - 1));
        for (int j = 0; j < 2; j++) begin
            check("commit_id", 32'(cid[j*3 +: 3]), 32'((head + j) % 8));
            check("illegal", 32'(cill[j]), (j < q.size()) ? 32'(q[j].ill) : 32'd0);
        end
        check("alloc_id", 32'(alloc_id), 32'(alloc % 8));
        check("full", 32'(full), 32'(q.size() == 8));
        check("bitmap", 32'(bitmap), 32'(bm));
`ifdef RVV_COMMIT_PERF_EN
        check("perf_retired", perf_ret, m_ret);
        check("perf_stall", perf_stall, m_stall);
`else
        check("perf_retired", perf_ret, 32'd0);
        check("perf_stall", perf_stall, 32'd0);
`endif
    endtask

    // Apply one cycle of inputs (called at posedge+1), advance the model,
    // and check all outputs one cycle later.
    task automatic step(input bit iv, input bit ill, input logic [3:0] dv, input logic [11:0] did,
                        input bit cv, input logic [2:0] cidi, input bit rdy);
        int   n;
        bit   iss;
        int   tail;
        ent_t e;
        issue_valid  = iv;
        illegal_insn = ill;
        vfu_done     = dv;
        vfu_done_id  = did;
        cc_valid     = cv;
        cc_id        = cidi;
        cready       = rdy;
        #1;
        check("gnt", 32'(vfu_gnt), 32'(dv));
        n    = rdy ? exp_n() : 0;
        if (q.size() > 0 && exp_n() == 0) m_stall++;
        iss  = iv && (q.size() < 8);
        tail = alloc % 8;
        if (cv) bm[cidi] = 1'b1;
        for (int j = 0; j < n; j++) bm[q[j].id] = 1'b0;
        if (iss) bm[tail] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (dv[k]) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].id == did[k*3 +: 3]) begin
                        e = q[i];
                        e.done = 1'b1;
                        q[i] = e;
                    end
                end
            end
        end
        for (int j = 0; j < n; j++) q.delete(0);
        if (iss) begin
            e.id   = 3'(tail);
            e.done = 1'b0;
            e.ill  = ill;
            q.push_back(e);
            alloc++;
        end
        m_ret += n;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 4'b0, 12'b0, 1'b0, 3'b0, rdy);
    endtask

    task automatic issue(input bit ill);
        step(1'b1, ill, 4'b0, 12'b0, 1'b0, 3'b0, 1'b0);
    endtask

    task automatic done1(input int k, input logic [2:0] id, input bit rdy);
        logic [3:0]  dv;
        logic [11:0] did;
        dv  = 4'b0;
        did = 12'b0;
        dv[k] = 1'b1;
        did[k*3 +: 3] = id;
        step(1'b0, 1'b0, dv, did, 1'b0, 3'b0, rdy);
    endtask

    task automatic do_reset();
        #2;
        rst_ni       = 1'b0;
        issue_valid  = 1'b0;
        illegal_insn = 1'b0;
        vfu_done     = '0;
        vfu_done_id  = '0;
        cc_valid     = 1'b0;
        cc_id        = '0;
        cready       = 1'b0;
        #1;
        check("rst_valid", 32'(cvalid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_alloc", 32'(alloc_id), 32'd0);
        check("rst_bitmap", 32'(bitmap), 32'd0);
        check("rst_perf", perf_ret | perf_stall, 32'd0);
        q.delete();
        alloc   = 0;
        bm      = '0;
        m_ret   = 0;
        m_stall = 0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [3:0]  dv;
        logic [11:0] did;
        logic [2:0]  pend[$];
        int          idx;

        rst_ni       = 1'b1;
        issue_valid  = 1'b0;
        illegal_insn = 1'b0;
        vfu_done     = '0;
        vfu_done_id  = '0;
        cc_valid     = 1'b0;
        cc_id        = '0;
        cready       = 1'b0;
        #1;
        do_reset();

        // Basic: IDs 0,1,2; ID1 completes, then ID0; both lanes valid together.
        issue(1'b0); issue(1'b0); issue(1'b0);
        done1(1, 3'd1, 1'b0);
        check("basic_wait", 32'(cvalid), 32'd0);
        done1(0, 3'd0, 1'b0);
        check("basic_lanes", 32'(cvalid), 32'd3);
        idle(1'b1);
        check("basic_id2_pending", 32'(cvalid), 32'd0);
        done1(2, 3'd2, 1'b0);
        check("basic_id2_valid", 32'(cvalid), 32'd1);
        check("basic_id2_id", 32'(cid[2:0]), 32'd2);
        idle(1'b1);

        // Multi-done: four completions in one cycle, out of order.
        do_reset();
        repeat (4) issue(1'b0);
        step(1'b0, 1'b0, 4'b1111, {3'd1, 3'd2, 3'd0, 3'd3}, 1'b0, 3'b0, 1'b0);
        check("multi_lanes", 32'(cvalid), 32'd3);
        check("multi_ids01", 32'(cid), 32'({3'd1, 3'd0}));
        idle(1'b1);
        check("multi_ids23", 32'(cid), 32'({3'd3, 3'd2}));
        check("multi_lanes2", 32'(cvalid), 32'd3);
        idle(1'b1);
        check("multi_empty", 32'(cvalid), 32'd0);

        // Illegal: retires the cycle after issue with no completion.
        do_reset();
        issue(1'b1);
        check("illegal_valid", 32'(cvalid[0]), 32'd1);
        check("illegal_flag", 32'(cill[0]), 32'd1);
        idle(1'b1);

        // Full/wrap: eight issues fill the window; retire two, then wrap.
        do_reset();
        repeat (8) issue(1'b0);
        check("full_set", 32'(full), 32'd1);
        check("wrap_alloc_full", 32'(alloc_id), 32'd0);
        step(1'b0, 1'b0, 4'b0011, {6'd0, 3'd1, 3'd0}, 1'b0, 3'b0, 1'b0);
        check("full_during_retire", 32'(full), 32'd1);
        idle(1'b1);
        check("full_cleared", 32'(full), 32'd0);
        check("wrap_alloc0", 32'(alloc_id), 32'd0);
        issue(1'b0);
        check("wrap_alloc1", 32'(alloc_id), 32'd1);

        // Backpressure: lanes hold while ready is low, lane 1 joins later.
        do_reset();
        issue(1'b0); issue(1'b0);
        done1(0, 3'd0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) done1(3, 3'd1, 1'b0);
            else        idle(1'b0);
            check("bp_lane0", 32'(cvalid[0]), 32'd1);
            check("bp_id0", 32'(cid[2:0]), 32'd0);
        end
        check("bp_both", 32'(cvalid), 32'd3);
        idle(1'b1);
        check("bp_drained", 32'(cvalid), 32'd0);

        // Bitmap and perf: set bit 4, then retire five instructions.
        do_reset();
        repeat (5) issue(1'b0);
        step(1'b0, 1'b0, 4'b0, 12'b0, 1'b1, 3'd4, 1'b0);
        check("bitmap_set4", 32'(bitmap[4]), 32'd1);
        idle(1'b0); idle(1'b0);
        step(1'b0, 1'b0, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0, 3'b0, 1'b0);
        done1(0, 3'd4, 1'b1);
        idle(1'b1); idle(1'b1);
        check("bitmap_clr4", 32'(bitmap[4]), 32'd0);
`ifdef RVV_COMMIT_PERF_EN
        check("perf_five", perf_ret, 32'd5);
`endif

        // Randomized traffic, with one asynchronous reset in the middle.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) do_reset();
            pend.delete();
            foreach (q[i]) if (!q[i].done && !q[i].ill) pend.push_back(q[i].id);
            dv  = '0;
            did = '0;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 2) == 0 && pend.size() > 0) begin
                    idx = $urandom_range(0, pend.size() - 1);
                    dv[k] = 1'b1;
                    did[k*3 +: 3] = pend[idx];
                    pend.delete(idx);
                end
            end
            step((q.size() < 8) && ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0),
                 dv, did,
                 ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
